pwm_capture: RTL

- Receive side of the 1-bit PWM audio format: recovers 7-bit sample levels from an incoming PWM stream.
- Stream format: 128-clock period; duty = number of high clocks per period.
- On a start pulse, records 128 samples at the 5120 Hz sample rate and writes them into a 128x7 sample RAM.
- The stored samples can later be played back through the existing PWM sound path.

---
 rtl/audio_pkg.sv | 15 +
 rtl/pwm_capture_if.sv | 41 ++++
 rtl/pwm_capture_demod.sv | 45 ++++
 rtl/pwm_capture.sv | 114 +++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared constants and capture FSM state type for the PWM audio blocks.
package audio_pkg;

  localparam int unsigned SAMPLE_W          = 7;
  localparam int unsigned PWM_PERIOD        = 128;
  localparam int unsigned SAMPLE_DEPTH      = 128;
  localparam int unsigned SAMPLE_DIV_5120HZ = 9766;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } capture_state_t;

endpackage

// File: rtl/pwm_capture_if.sv
// Capture-side signal bundle: PWM input, start handshake, demodulated level and sample RAM write port.
interface pwm_capture_if #(
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned LEVEL_W = 7
);

  logic               pwm_in;
  logic               start;
  logic               busy;
  logic               done;
  logic               level_valid;
  logic [LEVEL_W-1:0] level;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [LEVEL_W-1:0] wr_data;

  modport master (
    input  pwm_in,
    input  start,
    output busy,
    output done,
    output level_valid,
    output level,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    output pwm_in,
    output start,
    input  busy,
    input  done,
    input  level_valid,
    input  level,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

endinterface

// File: rtl/pwm_capture_demod.sv
// Free-running PWM demodulator: counts high clocks over each 2^PERIOD_W clock window.
module pwm_demod #(
  parameter int unsigned PERIOD_W = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pwm_in,
  output logic [PERIOD_W-1:0] level,
  output logic                level_valid
);

  logic                sync1;
  logic                pwm_s;
  logic [PERIOD_W-1:0] phase;
  logic [PERIOD_W:0]   high_cnt;
  logic [PERIOD_W:0]   total;

  // Window total includes the sample arriving on the closing cycle.
  assign total = high_cnt + {{PERIOD_W{1'b0}}, pwm_s};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1       <= 1'b0;
      pwm_s       <= 1'b0;
      phase       <= '0;
      high_cnt    <= '0;
      level       <= '0;
      level_valid <= 1'b0;
    end else begin
      sync1       <= pwm_in;
      pwm_s       <= sync1;
      phase       <= phase + 1'b1;
      level_valid <= 1'b0;
      if (phase == '1) begin
        // A fully-high window (2^PERIOD_W) does not fit the level width.
        level       <= total[PERIOD_W] ? '1 : total[PERIOD_W-1:0];
        level_valid <= 1'b1;
        high_cnt    <= '0;
      end else begin
        high_cnt <= total;
      end
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// PWM capture top: demodulates the input stream and stores 2^ADDR_W levels at the sample rate.
module pwm_capture
  import audio_pkg::*;
#(
  parameter int unsigned PERIOD_W   = 7,
  parameter int unsigned SAMPLE_DIV = SAMPLE_DIV_5120HZ,
  parameter int unsigned DIV_W      = 14,
  parameter int unsigned ADDR_W     = 7
) (
  input  logic           clk,
  input  logic           rst,
  pwm_capture_if.master  bus
);

  if (SAMPLE_DIV < (1 << PERIOD_W)) begin : g_div_too_small
    $error("SAMPLE_DIV must be at least one full PWM period");
  end
  if (SAMPLE_DIV > (1 << DIV_W)) begin : g_div_too_wide
    $error("SAMPLE_DIV does not fit in DIV_W bits");
  end

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  logic [PERIOD_W-1:0] level;
  logic                level_valid;
  capture_state_t      state;
  logic [DIV_W-1:0]    div_cnt;
  logic [ADDR_W-1:0]   addr;
  logic                tick;
  logic                busy;
  logic                done;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [PERIOD_W-1:0] wr_data;

  pwm_demod #(
    .PERIOD_W (PERIOD_W)
  ) u_demod (
    .clk         (clk),
    .rst         (rst),
    .pwm_in      (bus.pwm_in),
    .level       (level),
    .level_valid (level_valid)
  );

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      addr    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= CAPTURE;
            addr    <= '0;
            div_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        CAPTURE: begin
          // A restart suppresses any write due on the same cycle.
          if (bus.start) begin
            addr    <= '0;
            div_cnt <= '0;
          end else if (tick) begin
            div_cnt <= '0;
            wr_en   <= 1'b1;
            wr_addr <= addr;
            wr_data <= level;
            addr    <= addr + 1'b1;
            if (addr == '1) state <= DONE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DONE: begin
          done <= 1'b1;
          if (bus.start) begin
            state   <= CAPTURE;
            addr    <= '0;
            div_cnt <= '0;
            busy    <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.level       = level;
  assign bus.level_valid = level_valid;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.wr_en       = wr_en;
  assign bus.wr_addr     = wr_addr;
  assign bus.wr_data     = wr_data;

endmodule
